// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: register page offsets
// and STATUS bit positions.
package dmem_mmio_responder_pkg;

    localparam logic [3:0] LED_OFS   = 4'h0;
    localparam logic [3:0] TIMER_OFS = 4'h4;
    localparam logic [3:0] FIFO_OFS  = 4'h8;
    localparam logic [3:0] STAT_OFS  = 4'hC;

    localparam int STAT_FULL_BIT  = 8;
    localparam int STAT_EMPTY_BIT = 9;
    localparam int STAT_OVF_BIT   = 16;
    localparam int STAT_BAD_BIT   = 17;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Core-side data-memory bus plus the valid/ready drain port of the output FIFO.
interface dmem_mmio_responder_if;
    import dmem_mmio_responder_pkg::*;

    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport slave (
        input  memwrite, dataadr, writedata, out_ready,
        output readdata, out_valid, out_data
    );

    modport master (
        output memwrite, dataadr, writedata, out_ready,
        input  readdata, out_valid, out_data
    );

endinterface

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is still accepted when a pop
// happens in the same cycle. Head reads as zero when empty.
module sync_fifo
    import dmem_mmio_responder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus a register
// page with LEDs, a free-running timer, an output FIFO and sticky status.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000FF00
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_mmio_responder_if.slave  bus,
    output logic [7:0]            leds
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              in_ram;
    logic              in_page;
    logic [3:0]        ofs;

    logic [7:0]        led_reg;
    logic [31:0]       timer;
    logic              overflow;
    logic              bad_addr;

    logic              fifo_wr;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       fifo_head;
    logic [31:0]       status;

    logic              ram_wr;
    logic              led_wr;
    logic              timer_wr;
    logic              stat_wr;
    logic              ovf_set;
    logic              bad_set;

    assign ram_idx = bus.dataadr[RAM_AW+1:2];
    assign in_ram  = bus.dataadr < 32'(RAM_WORDS * 4);
    assign in_page = bus.dataadr[31:4] == MMIO_BASE[31:4];
    assign ofs     = {bus.dataadr[3:2], 2'b00};

    assign ram_wr   = bus.memwrite && in_ram;
    assign led_wr   = bus.memwrite && in_page && (ofs == LED_OFS);
    assign timer_wr = bus.memwrite && in_page && (ofs == TIMER_OFS);
    assign fifo_wr  = bus.memwrite && in_page && (ofs == FIFO_OFS);
    assign stat_wr  = bus.memwrite && in_page && (ofs == STAT_OFS);
    assign fifo_pop = bus.out_valid && bus.out_ready;
    assign ovf_set  = fifo_wr && fifo_full && !fifo_pop;
    assign bad_set  = bus.memwrite && !in_ram && !in_page;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_wr),
        .wdata (bus.writedata),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head;
    assign leds          = led_reg;

    always_ff @(posedge clk) begin
        if (ram_wr) ram[ram_idx] <= bus.writedata;
    end

    // Sticky bits: a set event in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg  <= '0;
            timer    <= '0;
            overflow <= 1'b0;
            bad_addr <= 1'b0;
        end else begin
            if (led_wr) led_reg <= bus.writedata[7:0];
            timer <= timer_wr ? bus.writedata : timer + 32'd1;
            if (ovf_set)
                overflow <= 1'b1;
            else if (stat_wr && bus.writedata[STAT_OVF_BIT])
                overflow <= 1'b0;
            if (bad_set)
                bad_addr <= 1'b1;
            else if (stat_wr && bus.writedata[STAT_BAD_BIT])
                bad_addr <= 1'b0;
        end
    end

    always_comb begin
        status                 = '0;
        status[7:0]            = 8'(fifo_count);
        status[STAT_FULL_BIT]  = fifo_full;
        status[STAT_EMPTY_BIT] = fifo_empty;
        status[STAT_OVF_BIT]   = overflow;
        status[STAT_BAD_BIT]   = bad_addr;
    end

    always_comb begin
        bus.readdata = '0;
        if (in_ram) begin
            bus.readdata = ram[ram_idx];
        end else if (in_page) begin
            case (ofs)
                LED_OFS:   bus.readdata = {24'b0, led_reg};
                TIMER_OFS: bus.readdata = timer;
                FIFO_OFS:  bus.readdata = fifo_head;
                STAT_OFS:  bus.readdata = status;
                default:   bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder.
module tb_dmem_mmio_responder;

    localparam logic [31:0] BASE = 32'h0000FF00;
    localparam logic [31:0] A_LED   = BASE + 32'h0;
    localparam logic [31:0] A_TIMER = BASE + 32'h4;
    localparam logic [31:0] A_FIFO  = BASE + 32'h8;
    localparam logic [31:0] A_STAT  = BASE + 32'hC;

    logic       clk;
    logic       reset;
    logic [7:0] leds;
    int         vectors;
    int         miscompares;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .leds  (leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.memwrite  = 1'b1;
        bus.dataadr   = addr;
        bus.writedata = data;
        @(posedge clk);
        #1;
        bus.memwrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.dataadr  = addr;
        #1;
        data = bus.readdata;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = '0;
        bus.writedata = '0;
        bus.out_ready = 1'b0;
        #3;
        check("reset_leds", {24'b0, leds}, 32'h0);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("reset_out_data", bus.out_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_STAT, rd);
        check("reset_status", rd, 32'h0000_0200);
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        bus_write(32'h40, 32'hDEADBEEF);
        bus_write(32'h44, 32'h12345678);
        bus_read(32'h40, rd);
        check("ram_0x40", rd, 32'hDEADBEEF);
        bus_read(32'h44, rd);
        check("ram_0x44", rd, 32'h12345678);
    endtask

    task automatic test_led_async_reset();
        logic [31:0] rd;
        bus_write(A_LED, 32'hFFFF_FFA5);
        check("led_port", {24'b0, leds}, 32'hA5);
        bus_read(A_LED, rd);
        check("led_read", rd, 32'h0000_00A5);
        bus_write(A_FIFO, 32'h77);
        check("pre_reset_valid", {31'b0, bus.out_valid}, 32'h1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_leds", {24'b0, leds}, 32'h0);
        check("async_flush_valid", {31'b0, bus.out_valid}, 32'h0);
        check("async_flush_data", bus.out_data, 32'h0);
        #1 reset = 1'b0;
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'hFFFF_FFFE;
        exp_seq[1] = 32'hFFFF_FFFF;
        exp_seq[2] = 32'h0000_0000;
        exp_seq[3] = 32'h0000_0001;
        bus_write(A_TIMER, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_TIMER, rd);
            check($sformatf("timer_%0d", i), rd, exp_seq[i]);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] rd;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) bus_write(A_FIFO, 32'(k));
        bus_read(A_STAT, rd);
        check("ovf_status", rd, 32'h0001_0108);
        check("ovf_head", bus.out_data, 32'h1);
        bus_read(A_FIFO, rd);
        check("fifo_peek", rd, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("drain_valid_%0d", k), {31'b0, bus.out_valid}, 32'h1);
            check($sformatf("drain_data_%0d", k), bus.out_data, 32'(k));
        end
        bus_read(A_STAT, rd);
        bus.out_ready = 1'b0;
        check("drained_status", rd, 32'h0001_0200);
        check("drained_data", bus.out_data, 32'h0);
        bus_write(A_STAT, 32'h0001_0000);
        bus_read(A_STAT, rd);
        check("ovf_cleared", rd, 32'h0000_0200);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp_seq [8];
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) bus_write(A_FIFO, 32'h11 + 32'(k));
        @(negedge clk);
        bus.memwrite  = 1'b1;
        bus.dataadr   = A_FIFO;
        bus.writedata = 32'h99;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.memwrite  = 1'b0;
        bus.out_ready = 1'b0;
        bus_read(A_STAT, rd);
        check("pushpop_status", rd, 32'h0000_0108);
        for (int k = 0; k < 7; k++) exp_seq[k] = 32'h12 + 32'(k);
        exp_seq[7] = 32'h99;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("pushpop_data_%0d", k), bus.out_data, exp_seq[k]);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("pushpop_empty", {31'b0, bus.out_valid}, 32'h0);
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd;
        bus_write(32'h0, 32'hCAFEF00D);
        bus_write(32'h2000, 32'h5555_5555);
        bus_read(32'h0, rd);
        check("bad_no_ram_change", rd, 32'hCAFEF00D);
        bus_read(32'h2000, rd);
        check("bad_read_zero", rd, 32'h0);
        bus_read(A_STAT, rd);
        check("bad_status", rd, 32'h0002_0200);
        bus_write(A_STAT, 32'h0002_0000);
        bus_read(A_STAT, rd);
        check("bad_cleared", rd, 32'h0000_0200);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        $display("[TB] starting dmem_mmio_responder bench");
        test_reset();
        test_ram();
        test_led_async_reset();
        test_timer();
        test_fifo_overflow();
        test_back_to_back();
        test_bad_addr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the processor data-memory interface: consumes memwrite/dataadr/writedata from the MIPS core and returns readdata.
- Contains a word RAM plus a memory-mapped register page: LED register, free-running cycle timer, output FIFO with a valid/ready drain port, and a status register.
- Sits beside the core inside top, replacing the plain data memory.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, at most 256.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.
- MMIO_BASE, 32'h0000FF00, byte address of the register page; 16-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- memwrite  in  1  store strobe from the core, sampled on the clk rising edge.
- dataadr  in  32  byte address from the core; bits [1:0] ignored.
- writedata  in  32  store data from the core.
- readdata  out  32  load data; combinational from dataadr and current state.
- leds  out  8  LED register contents.
- out_valid  out  1  FIFO non-empty.
- out_data  out  32  FIFO head word.
- out_ready  in  1  downstream accepts the head word.

Behaviour:
- Reset is asynchronous, active-high. It clears leds, timer, FIFO pointers and count, and both sticky bits. out_valid=0, out_data=0.
- RAM contents are not reset.
- Address map:
  - RAM: dataadr < RAM_WORDS*4, word index dataadr[log2(RAM_WORDS)+1:2].
  - MMIO_BASE+0x0: LED register (RW, bits [7:0]; reads are zero-extended).
  - MMIO_BASE+0x4: TIMER (RW).
  - MMIO_BASE+0x8: FIFO_DATA (write pushes; read returns the head word without popping, or 0 when empty).
  - MMIO_BASE+0xC: STATUS.
  - Anything else is unmapped.
- Reads: zero latency and combinational, matching the single-cycle core. Unmapped reads return 0.
- Writes: take effect at the clk edge where memwrite=1. An unmapped write is ignored and sets sticky bad_addr.
- TIMER:
  - Increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A write loads writedata, and the load overrides the increment that cycle.
- FIFO:
  - push = memwrite to FIFO_DATA. pop = out_valid & out_ready.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push leaves the contents unchanged and sets sticky overflow.
  - Push and pop in the same cycle: count unchanged, head advances, the new word is written at the tail.
  - Empty plus push: no fall-through; out_valid rises the cycle after the push edge.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is the head entry when non-empty, otherwise 0.
- STATUS read: [7:0] count, [8] full, [9] empty, [16] overflow, [17] bad_addr, other bits 0.
- STATUS write: write-1-to-clear on bits 16 and 17; other bits are ignored.
  - If a clear coincides with a new set event in the same cycle, the set wins.
- Reset asserted mid-operation flushes the FIFO immediately; any queued data is lost.

Decomposition:
- Shared package holds the register offset constants (LED_OFS, TIMER_OFS, FIFO_OFS, STAT_OFS) and the STATUS bit positions.
- One natural sub-module: sync_fifo, parameterised depth/width, exposing push/pop/full/empty/count and head data.
- Address decode, RAM, timer and registers stay in the top module.

Test Plan:
- Reset, then store 0xDEADBEEF to address 0x40 and load from 0x40 -> readdata=0xDEADBEEF. A load from 0x44 after writing 0x12345678 there returns 0x12345678.
- Write 0xA5 to LED, then read it -> leds=0xA5 and readdata=0x000000A5. Reset mid-run -> leds=0 asynchronously, before the next edge.
- Write TIMER=0xFFFFFFFE, then idle 3 cycles -> reads 0xFFFFFFFF, 0x00000000, 0x00000001.
- With out_ready=0, push 1..9 -> count=8, full=1, overflow=1, out_data=1. Raise out_ready -> words 1..8 drain in order, empty=1. Write STATUS 0x10000 -> overflow=0.
- With the FIFO full, push 0x99 in the same cycle as a pop -> count stays 8, overflow stays 0, and 0x99 exits last.
- Store to 0x2000 -> no RAM change, bad_addr=1, and a load from 0x2000 returns 0.
